// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// With IMEM_LOAD_CHECKSUM_EN defined, the state set grows by CHECK and FAIL.
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 32;

`ifdef IMEM_LOAD_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, CLEAR, RECV, WRITE, DONE, CHECK, FAIL} state_t;
`else
    typedef enum logic [2:0] {IDLE, CLEAR, RECV, WRITE, DONE} state_t;
`endif

endpackage

// File: rtl/imem_word_assembler.sv
// Packs accepted bytes big-endian into a 32-bit word and keeps a running XOR
// of every byte accepted since the last clear.
module imem_word_assembler
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              accept,
    input  logic [7:0]        byte_data,
    output logic [WORD_W-1:0] word,
    output logic              word_done,
    output logic [7:0]        xor_sum
);

    logic [1:0] byte_cnt;

    // The fourth byte of a word completes it; the counter wraps 3->0 on the same edge.
    assign word_done = accept && (byte_cnt == 2'(BYTES_PER_WORD - 1));

    // Shift bytes in from the bottom so the first byte ends up in [31:24].
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word     <= '0;
            byte_cnt <= '0;
            xor_sum  <= '0;
        end else if (clear) begin
            word     <= '0;
            byte_cnt <= '0;
            xor_sum  <= '0;
        end else if (accept) begin
            word     <= {word[WORD_W-9:0], byte_data};
            byte_cnt <= byte_cnt + 2'd1;
            xor_sum  <= xor_sum ^ byte_data;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader for a writable instruction memory: zero-fills every entry, then
// writes a big-endian byte stream as 32-bit words from address 0 upward, holding
// the core in stall until the load completes.
// Optional macro IMEM_LOAD_CHECKSUM_EN adds a trailing XOR checksum byte, the
// CHECK/FAIL states and the load_err output.
module imem_boot_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_stall,
    output logic              busy,
    output logic              done
`ifdef IMEM_LOAD_CHECKSUM_EN
    ,
    output logic              load_err
`endif
);

    import imem_loader_pkg::*;

    localparam logic [ADDR_W:0]   DEPTH_N   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    // After the last data word the load either finishes or waits for the checksum.
`ifdef IMEM_LOAD_CHECKSUM_EN
    localparam state_t LOAD_END = CHECK;
`else
    localparam state_t LOAD_END = DONE;
`endif

    state_t            state, state_next;
    logic [ADDR_W-1:0] clr_addr;
    logic [ADDR_W:0]   word_idx;
    logic [ADDR_W:0]   n_words;
    logic [ADDR_W:0]   idx_inc;
    logic              launch;
    logic              clr_last;
    logic              asm_accept;
    logic              word_done;
    logic [WORD_W-1:0] asm_word;
    logic [7:0]        xor_sum;

    assign idx_inc    = word_idx + (ADDR_W+1)'(1);
    assign clr_last   = (clr_addr == LAST_ADDR);
    assign asm_accept = byte_valid && (state == RECV);

    // A start is honoured only from a resting state; elsewhere it is ignored.
`ifdef IMEM_LOAD_CHECKSUM_EN
    assign launch = start && (state == IDLE || state == DONE || state == FAIL);
`else
    assign launch = start && (state == IDLE || state == DONE);
`endif

    imem_word_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (launch),
        .accept    (asm_accept),
        .byte_data (byte_data),
        .word      (asm_word),
        .word_done (word_done),
        .xor_sum   (xor_sum)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of block ordering.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (launch) state_next = CLEAR;
            CLEAR:   if (clr_last) state_next = (n_words == '0) ? LOAD_END : RECV;
            RECV:    if (word_done) state_next = WRITE;
            WRITE:   state_next = (idx_inc == n_words) ? LOAD_END : RECV;
            DONE:    if (launch) state_next = CLEAR;
`ifdef IMEM_LOAD_CHECKSUM_EN
            CHECK:   if (byte_valid) state_next = (byte_data == xor_sum) ? DONE : FAIL;
            FAIL:    if (launch) state_next = CLEAR;
`endif
            default: state_next = IDLE;
        endcase
    end

    // Clear address, word index and the clamped word count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_addr <= '0;
            word_idx <= '0;
            n_words  <= '0;
        end else if (launch) begin
            clr_addr <= '0;
            word_idx <= '0;
            n_words  <= (word_count > DEPTH_N) ? DEPTH_N : word_count;
        end else if (state == CLEAR) begin
            clr_addr <= clr_last ? '0 : clr_addr + ADDR_W'(1);
        end else if (state == WRITE) begin
            word_idx <= idx_inc;
        end
    end

    // Output decode from registered state and counters only.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case
        // leaves one unassigned and infers a latch.
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        cpu_stall  = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
        load_err   = 1'b0;
`endif
        case (state)
            CLEAR: begin
                mem_we   = 1'b1;
                mem_addr = clr_addr;
                busy     = 1'b1;
            end
            RECV: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
            WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = word_idx[ADDR_W-1:0];
                mem_wdata = asm_word;
                busy      = 1'b1;
            end
            DONE: begin
                done      = 1'b1;
                cpu_stall = 1'b0;
            end
`ifdef IMEM_LOAD_CHECKSUM_EN
            CHECK:   byte_ready = 1'b1;
            FAIL:    load_err   = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: table-driven loads with random data
// and byte gaps, checked against a write log and a byte-timing model, plus
// hand-written reset and checksum sequences (checksum parts under
// IMEM_LOAD_CHECKSUM_EN).
module tb_imem_boot_loader;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
    localparam int WORD_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W:0]   word_count;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              cpu_stall;
    logic              busy;
    logic              done;
`ifdef IMEM_LOAD_CHECKSUM_EN
    logic              load_err;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int wc;       // word_count driven on start
        int gap_max;  // max idle cycles before each byte
        bit pulse;    // pulse start randomly while loading
        int pat;      // 0 random bytes, 1 example program, 2 12345678
        int exp_n;    // words expected after clamping
        bit bad_cs;   // send a wrong checksum byte
    } vec_t;

    wr_t         wlog[$];
    logic [31:0] tb_mem [DEPTH];
    vec_t        tbl [6];
    vec_t        v_seq;

    imem_boot_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .word_count (word_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_stall  (cpu_stall),
        .busy       (busy),
        .done       (done)
`ifdef IMEM_LOAD_CHECKSUM_EN
        ,
        .load_err   (load_err)
`endif
    );

    always #5 clk = ~clk;

    // Memory model behind the write port, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset === 1'b0 && mem_we === 1'b1) begin
            wlog.push_back('{int'(mem_addr), mem_wdata});
            tb_mem[mem_addr] = mem_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(byte_ready), 32'd0);
        check({tag, "_we"},    32'(mem_we),     32'd0);
        check({tag, "_addr"},  32'(mem_addr),   32'd0);
        check({tag, "_wdata"}, mem_wdata,       32'd0);
        check({tag, "_stall"}, 32'(cpu_stall),  32'd1);
        check({tag, "_busy"},  32'(busy),       32'd0);
        check({tag, "_done"},  32'(done),       32'd0);
    endtask

    // One load: build stream, predict timing, drive, then check log and flags.
    // abort_after > 0 returns right after that many bytes were accepted.
    task automatic run_load(input vec_t v, input int abort_after);
        logic [7:0]  q[$];
        int          gaps[$];
        logic [31:0] exp_words[$];
        logic [7:0]  pat1 [12];
        logic [7:0]  pat2 [4];
        logic [7:0]  cs;
        int          n, a_prev, ready_e, offer_e, exp_edge, idx, next_offer, end_edge, budget;
        bit          acc, saw_ready, ended;

        pat1 = '{8'h20, 8'ha5, 8'h00, 8'h0a, 8'h0c, 8'h00, 8'h00, 8'h03, 8'h08, 8'h00, 8'h00, 8'h5c};
        pat2 = '{8'h12, 8'h34, 8'h56, 8'h78};
        n = v.exp_n;
        cs = 8'h00;
        for (int k = 0; k < 4 * n; k++) begin
            if (v.pat == 1)      q.push_back(pat1[k]);
            else if (v.pat == 2) q.push_back(pat2[k]);
            else                 q.push_back(8'($urandom));
        end
        for (int w = 0; w < n; w++)
            exp_words.push_back({q[4*w], q[4*w+1], q[4*w+2], q[4*w+3]});
        if (v.pat == 1) exp_words = '{32'h20a5000a, 32'h0c000003, 32'h0800005c};
`ifdef IMEM_LOAD_CHECKSUM_EN
        foreach (q[k]) cs = cs ^ q[k];
        if (v.pat == 2)    cs = v.bad_cs ? 8'h09 : 8'h08;
        else if (v.bad_cs) cs = cs ^ 8'h01;
        q.push_back(cs);
`endif
        foreach (q[k]) gaps.push_back(v.gap_max > 0 ? int'($urandom_range(v.gap_max, 0)) : 0);

        // Timing model: edge 0 accepts start; first byte can land at edge DEPTH+1;
        // a new word waits one extra edge for the WRITE cycle.
        a_prev = 0;
        foreach (q[k]) begin
            offer_e = a_prev + 1 + gaps[k];
            if (k == 0)          ready_e = DEPTH + 1;
            else if (k % 4 == 0) ready_e = a_prev + 2;
            else                 ready_e = a_prev + 1;
            a_prev = (offer_e > ready_e) ? offer_e : ready_e;
        end
`ifdef IMEM_LOAD_CHECKSUM_EN
        exp_edge = a_prev;
`else
        exp_edge = (n == 0) ? DEPTH : a_prev + 1;
`endif

        wlog.delete();
        start      = 1'b1;
        word_count = (ADDR_W+1)'(v.wc);
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        tick();
        start      = 1'b0;

        idx        = 0;
        next_offer = 1 + ((gaps.size() > 0) ? gaps[0] : 0);
        end_edge   = -1;
        saw_ready  = 1'b0;
        budget     = exp_edge + 64;
        for (int e = 1; e <= budget; e++) begin
            byte_valid = (idx < q.size()) && (e >= next_offer);
            byte_data  = byte_valid ? q[idx] : 8'($urandom);
            start      = v.pulse && (e < exp_edge) && ($urandom_range(3, 0) == 0);
            word_count = (ADDR_W+1)'($urandom);
            if (byte_ready) saw_ready = 1'b1;
            acc = byte_valid && byte_ready;
            tick();
            if (acc) begin
                idx++;
                if (idx < q.size()) next_offer = e + 1 + gaps[idx];
                if (abort_after > 0 && idx == abort_after) begin
                    byte_valid = 1'b0;
                    start      = 1'b0;
                    return;
                end
            end
`ifdef IMEM_LOAD_CHECKSUM_EN
            ended = done || load_err;
`else
            ended = done;
`endif
            if (ended) begin
                end_edge = e;
                break;
            end
        end
        start      = 1'b0;
        byte_valid = 1'b0;

        check("end_edge", 32'(end_edge), 32'(exp_edge));
        check("done",     32'(done),      v.bad_cs ? 32'd0 : 32'd1);
        check("stall",    32'(cpu_stall), v.bad_cs ? 32'd1 : 32'd0);
        check("busy_end", 32'(busy),      32'd0);
        check("ready_end", 32'(byte_ready), 32'd0);
`ifdef IMEM_LOAD_CHECKSUM_EN
        check("load_err", 32'(load_err),  v.bad_cs ? 32'd1 : 32'd0);
`else
        if (n == 0) check("ready_never", 32'(saw_ready), 32'd0);
`endif
        check("log_size", 32'(wlog.size()), 32'(DEPTH + n));
        for (int i = 0; i < DEPTH; i++) begin
            if (i < wlog.size()) begin
                check("clear_addr", 32'(wlog[i].addr), 32'(i));
                check("clear_data", wlog[i].data, 32'd0);
            end
        end
        for (int w = 0; w < n; w++) begin
            if (DEPTH + w < wlog.size()) begin
                check("write_addr", 32'(wlog[DEPTH+w].addr), 32'(w));
                check("write_data", wlog[DEPTH+w].data, exp_words[w]);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        word_count = '0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        #2;
        check_reset_outputs("rst");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        tick();
        check_reset_outputs("idle");

        //         wc  gap pulse pat  n  bad
        tbl[0] = '{ 3,  0,  0,    1,  3, 0};
        tbl[1] = '{ 0,  0,  0,    0,  0, 0};
        tbl[2] = '{40,  0,  0,    0, 32, 0};
        tbl[3] = '{ 5,  3,  1,    0,  5, 0};
        tbl[4] = '{32,  2,  1,    0, 32, 0};
        tbl[5] = '{ 1,  1,  0,    0,  1, 0};
        foreach (tbl[i]) run_load(tbl[i], 0);

        // Reset after two bytes of word 1: immediate reset values, word 0 kept.
        v_seq = '{3, 0, 0, 1, 3, 0};
        run_load(v_seq, 6);
        #1 reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        check("keep_word0", tb_mem[0], 32'h20a5000a);
        check("no_partial", tb_mem[1], 32'd0);
        @(negedge clk) reset = 1'b0;
        v_seq = '{3, 1, 1, 0, 3, 0};
        run_load(v_seq, 0);

`ifdef IMEM_LOAD_CHECKSUM_EN
        v_seq = '{1, 0, 0, 2, 1, 0};
        run_load(v_seq, 0);
        v_seq = '{1, 0, 0, 2, 1, 1};
        run_load(v_seq, 0);
        v_seq = '{0, 0, 0, 0, 0, 0};
        run_load(v_seq, 0);
        v_seq = '{2, 2, 0, 0, 2, 0};
        run_load(v_seq, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
